// File: rtl/gan_axis_frame_framer_pkg.sv
// Shared types and constants for the GAN pixel framer.
// Mode/flow encodings and default pixel geometry.
package gan_axis_frame_framer_pkg;

  typedef enum logic {
    MODE_FORCE  = 1'b0,
    MODE_RESYNC = 1'b1
  } mode_e;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } flow_e;

  localparam int PIXEL_W      = 16;
  localparam int FRAME_PIXELS = 784;

endpackage

// File: rtl/gan_axis_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output.
// The output register counts toward DEPTH; an empty FIFO loads it directly.
module gan_axis_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             slot;
  logic             direct;
  logic             load;
  logic             wr;

  assign slot   = !valid || ready;
  assign direct = push && (cnt == '0) && slot;
  assign load   = (cnt != '0) && slot;
  assign wr     = push && !direct;
  assign full   = (cnt + (AW+1)'(valid)) == (AW+1)'(DEPTH);
  assign empty  = (cnt == '0) && !valid;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (load) begin
        dout <= mem[rp];
        rp   <= rp + AW'(1);
      end else if (direct) begin
        dout <= din;
      end
      cnt   <= cnt + (AW+1)'(wr) - (AW+1)'(load);
      valid <= direct || load || (valid && !ready);
    end
  end

endmodule

// File: rtl/gan_axis_frame_framer.sv
// AXI-Stream pixel framer: buffers beats and enforces a runtime frame length.
// Regenerates or checks TLAST, drops overrun beats, keeps sticky status.
module gan_axis_frame_framer
  import gan_axis_frame_framer_pkg::*;
#(
  parameter int DATA_W    = PIXEL_W,
  parameter int DEPTH     = 16,
  parameter int MAX_FRAME = FRAME_PIXELS,
  parameter int CNT_W     = 16,
  localparam int LEN_W    = $clog2(MAX_FRAME + 1)
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              cfg_enable,
  input  logic              cfg_mode,
  input  logic [LEN_W-1:0]  cfg_frame_len,
  input  logic              stat_clear,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [CNT_W-1:0]  stat_frame_count,
  output logic              stat_err_short,
  output logic              stat_err_long,
  output logic              stat_err_cfg,
  output logic              stat_busy
);

  logic [LEN_W-1:0] beat_idx, beat_idx_n;
  logic [LEN_W-1:0] len_q, len_n, len_cur;
  mode_e            mode_q, mode_n, mode_cur;
  flow_e            flow_q, flow_n;
  logic             full, empty;
  logic             accept, first, len_bad, at_end;
  logic             push, out_last;
  logic             ev_short, ev_long, ev_cfg;
  logic             frame_done;

  assign s_axis_tready = !axi_areset &&
    (flow_q == ST_DROP ||
     (!full && (beat_idx != '0 || cfg_enable)));
  assign accept     = s_axis_tvalid && s_axis_tready;
  assign first      = beat_idx == '0;
  assign len_bad    = cfg_frame_len == '0 ||
                      cfg_frame_len > LEN_W'(MAX_FRAME);
  assign len_cur    = !first ? len_q :
                      len_bad ? LEN_W'(MAX_FRAME) : cfg_frame_len;
  assign mode_cur   = first ? mode_e'(cfg_mode) : mode_q;
  assign at_end     = beat_idx == len_cur - LEN_W'(1);
  assign frame_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign stat_busy  = !first || !empty;

  always_comb begin
    beat_idx_n = beat_idx;
    len_n      = len_q;
    mode_n     = mode_q;
    flow_n     = flow_q;
    push       = 1'b0;
    out_last   = 1'b0;
    ev_short   = 1'b0;
    ev_long    = 1'b0;
    ev_cfg     = 1'b0;
    if (accept) begin
      if (flow_q == ST_DROP) begin
        if (s_axis_tlast) flow_n = ST_PASS;
      end else begin
        push     = 1'b1;
        len_n    = len_cur;
        mode_n   = mode_cur;
        ev_cfg   = first && len_bad;
        ev_short = s_axis_tlast && !at_end;
        out_last = at_end ||
                   (mode_cur == MODE_RESYNC && s_axis_tlast);
        // forced frames only flag an early input TLAST
        if (mode_cur == MODE_RESYNC && at_end && !s_axis_tlast) begin
          ev_long = 1'b1;
          flow_n  = ST_DROP;
        end
        beat_idx_n = out_last ? '0 : beat_idx + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      beat_idx         <= '0;
      len_q            <= '0;
      mode_q           <= MODE_FORCE;
      flow_q           <= ST_PASS;
      stat_err_short   <= 1'b0;
      stat_err_long    <= 1'b0;
      stat_err_cfg     <= 1'b0;
      stat_frame_count <= '0;
    end else begin
      beat_idx         <= beat_idx_n;
      len_q            <= len_n;
      mode_q           <= mode_n;
      flow_q           <= flow_n;
      stat_err_short   <= (stat_err_short && !stat_clear) || ev_short;
      stat_err_long    <= (stat_err_long && !stat_clear) || ev_long;
      stat_err_cfg     <= (stat_err_cfg && !stat_clear) || ev_cfg;
      stat_frame_count <= (stat_clear ? '0 : stat_frame_count) +
                          CNT_W'(frame_done);
    end
  end

  gan_axis_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (axi_aclk),
    .rst   (axi_areset),
    .push  (push),
    .din   ({out_last, s_axis_tdata}),
    .full  (full),
    .empty (empty),
    .dout  ({m_axis_tlast, m_axis_tdata}),
    .valid (m_axis_tvalid),
    .ready (m_axis_tready)
  );

endmodule

// File: tb/tb_gan_axis_frame_framer.sv
// Randomized bench for the pixel framer against a frame-level reference model.
// Directed scenarios plus random traffic with a per-beat scoreboard.
module tb_gan_axis_frame_framer;
  import gan_axis_frame_framer_pkg::*;

  localparam int DATA_W    = 16;
  localparam int DEPTH     = 16;
  localparam int MAX_FRAME = 784;
  localparam int CNT_W     = 16;
  localparam int LEN_W     = 10;

  logic              axi_aclk = 1'b0;
  logic              axi_areset = 1'b1;
  logic              cfg_enable = 1'b0;
  logic              cfg_mode = 1'b0;
  logic [LEN_W-1:0]  cfg_frame_len = 10'd4;
  logic              stat_clear = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tlast = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic [CNT_W-1:0]  stat_frame_count;
  logic              stat_err_short;
  logic              stat_err_long;
  logic              stat_err_cfg;
  logic              stat_busy;

  gan_axis_frame_framer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .MAX_FRAME (MAX_FRAME),
    .CNT_W     (CNT_W)
  ) dut (
    .axi_aclk         (axi_aclk),
    .axi_areset       (axi_areset),
    .cfg_enable       (cfg_enable),
    .cfg_mode         (cfg_mode),
    .cfg_frame_len    (cfg_frame_len),
    .stat_clear       (stat_clear),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .stat_frame_count (stat_frame_count),
    .stat_err_short   (stat_err_short),
    .stat_err_long    (stat_err_long),
    .stat_err_cfg     (stat_err_cfg),
    .stat_busy        (stat_busy)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t inq[$];
  beat_t expq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_in, n_out;
  int vprob = 100;
  int rprob = 100;
  bit rnd_cfg = 1'b0;

  int m_pos, m_len;
  bit m_mode, m_drop;
  bit e_short, e_long, e_cfg;
  int e_cnt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_in(logic [DATA_W-1:0] d, logic l);
    bit is_end, olast;
    if (m_drop) begin
      if (l) m_drop = 1'b0;
      return;
    end
    if (m_pos == 0) begin
      m_mode = cfg_mode;
      m_len  = int'(cfg_frame_len);
      if (m_len == 0 || m_len > MAX_FRAME) begin
        m_len = MAX_FRAME;
        e_cfg = 1'b1;
      end
    end
    m_pos++;
    is_end = (m_pos == m_len);
    olast  = is_end || (m_mode && l);
    if (l && !is_end) e_short = 1'b1;
    if (is_end && !l && m_mode) begin
      e_long = 1'b1;
      m_drop = 1'b1;
    end
    expq.push_back({olast, d});
    if (olast) m_pos = 0;
  endtask

  task automatic cycle();
    bit ihs, ohs;
    beat_t x;
    #1;
    ihs = s_axis_tvalid && s_axis_tready;
    ohs = m_axis_tvalid && m_axis_tready;
    if (stat_clear) begin
      e_short = 1'b0;
      e_long  = 1'b0;
      e_cfg   = 1'b0;
      e_cnt   = 0;
    end
    if (ohs) begin
      chk("out_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        x = expq.pop_front();
        chk("out_data", 32'(m_axis_tdata), 32'(x.data));
        chk("out_last", 32'(m_axis_tlast), 32'(x.last));
        if (x.last) e_cnt++;
        n_out++;
      end
    end
    if (ihs) begin
      model_in(s_axis_tdata, s_axis_tlast);
      n_in++;
      if (inq.size() != 0) void'(inq.pop_front());
    end
    @(negedge axi_aclk);
  endtask

  task automatic drive();
    if (rnd_cfg) begin
      cfg_mode      = 1'($urandom_range(1));
      cfg_frame_len = LEN_W'($urandom_range(1, 6));
      cfg_enable    = ($urandom_range(99) < 85);
    end
    s_axis_tvalid = inq.size() != 0 && $urandom_range(99) < vprob;
    if (inq.size() != 0) begin
      s_axis_tdata = inq[0].data;
      s_axis_tlast = inq[0].last;
    end
    m_axis_tready = $urandom_range(99) < rprob;
  endtask

  task automatic run(string tag, int budget);
    int c = 0;
    while ((inq.size() != 0 || expq.size() != 0) && c < budget) begin
      drive();
      cycle();
      c++;
    end
    chk({tag, "_drain"}, 32'(inq.size() + expq.size()), 32'd0);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic load(int n, logic [63:0] lmask);
    for (int i = 0; i < n; i++)
      inq.push_back({(i < 64) ? lmask[i] : 1'b0, DATA_W'($urandom)});
  endtask

  task automatic do_reset();
    axi_areset    = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    stat_clear    = 1'b0;
    repeat (2) @(negedge axi_aclk);
    inq.delete();
    expq.delete();
    m_pos = 0; m_drop = 0;
    e_short = 0; e_long = 0; e_cfg = 0; e_cnt = 0;
    n_in = 0; n_out = 0;
    axi_areset = 1'b0;
  endtask

  task automatic check_stats(string tag);
    chk({tag, "_short"}, 32'(stat_err_short), 32'(e_short));
    chk({tag, "_long"}, 32'(stat_err_long), 32'(e_long));
    chk({tag, "_cfg"}, 32'(stat_err_cfg), 32'(e_cfg));
    chk({tag, "_cnt"}, 32'(stat_frame_count), 32'(e_cnt[15:0]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state, with enable high while in reset
    cfg_enable = 1'b1;
    repeat (2) @(negedge axi_aclk);
    #1;
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_mdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_mlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_cnt", 32'(stat_frame_count), 32'd0);
    chk("rst_errs", 32'({stat_err_short, stat_err_long, stat_err_cfg}), 32'd0);
    chk("rst_busy", 32'(stat_busy), 32'd0);
    @(negedge axi_aclk);
    cfg_enable = 1'b0;
    axi_areset = 1'b0;
    #1 chk("en_gate_off", 32'(s_axis_tready), 32'd0);
    cfg_enable = 1'b1;
    #1 chk("en_gate_on", 32'(s_axis_tready), 32'd1);
    @(negedge axi_aclk);

    // 1: forced frames of 4, no input TLAST
    do_reset();
    cfg_mode = MODE_FORCE; cfg_frame_len = 10'd4; cfg_enable = 1'b1;
    vprob = 100; rprob = 100;
    load(8, 64'd0);
    run("t1", 100);
    chk("t1_cnt", 32'(stat_frame_count), 32'd2);
    chk("t1_errs", 32'({stat_err_short, stat_err_long, stat_err_cfg}), 32'd0);
    check_stats("t1");

    // 2: resync, early TLAST on beat 3 then a normal frame
    do_reset();
    cfg_mode = MODE_RESYNC; cfg_frame_len = 10'd4;
    vprob = 70; rprob = 70;
    load(7, 64'b1000100);
    run("t2", 200);
    chk("t2_short", 32'(stat_err_short), 32'd1);
    chk("t2_long", 32'(stat_err_long), 32'd0);
    chk("t2_cnt", 32'(stat_frame_count), 32'd2);
    check_stats("t2");

    // 3: resync, 6-beat input frame against len 4
    do_reset();
    vprob = 100; rprob = 100;
    load(6, 64'b100000);
    run("t3", 200);
    chk("t3_long", 32'(stat_err_long), 32'd1);
    chk("t3_short", 32'(stat_err_short), 32'd0);
    chk("t3_cnt", 32'(stat_frame_count), 32'd1);
    chk("t3_nout", 32'(n_out), 32'd4);
    chk("t3_nin", 32'(n_in), 32'd6);

    // 4: fill with sink stalled, then drain without gaps
    do_reset();
    cfg_mode = MODE_FORCE;
    load(20, 64'd0);
    vprob = 100; rprob = 0;
    for (int i = 0; i < 30; i++) begin
      drive();
      cycle();
    end
    chk("t4_accepted", 32'(n_in), 32'd16);
    #1 chk("t4_tready", 32'(s_axis_tready), 32'd0);
    chk("t4_busy", 32'(stat_busy), 32'd1);
    @(negedge axi_aclk);
    vprob = 0; rprob = 100;
    for (int i = 0; i < 16; i++) begin
      drive();
      chk("t4_nogap", 32'(m_axis_tvalid), 32'd1);
      cycle();
    end
    chk("t4_nout", 32'(n_out), 32'd16);
    vprob = 100;
    run("t4", 200);
    chk("t4_cnt", 32'(stat_frame_count), 32'd5);

    // 5: zero length falls back to the maximum frame
    do_reset();
    cfg_mode = MODE_FORCE; cfg_frame_len = 10'd0;
    vprob = 80; rprob = 80;
    load(2 * MAX_FRAME, 64'd0);
    run("t5", 8000);
    chk("t5_cfg", 32'(stat_err_cfg), 32'd1);
    chk("t5_cnt", 32'(stat_frame_count), 32'd2);
    cfg_mode = MODE_RESYNC; cfg_frame_len = 10'd4;
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    s_axis_tdata = DATA_W'($urandom);
    stat_clear = 1'b1; m_axis_tready = 1'b0;
    cycle();
    s_axis_tvalid = 1'b0;
    chk("t5_clr_short", 32'(stat_err_short), 32'd1);
    chk("t5_clr_cfg", 32'(stat_err_cfg), 32'd0);
    chk("t5_clr_cnt", 32'(stat_frame_count), 32'd0);
    m_axis_tready = 1'b1;
    cycle();
    stat_clear = 1'b0;
    chk("t5_clr_cnt_inc", 32'(stat_frame_count), 32'd1);
    chk("t5_clr_short2", 32'(stat_err_short), 32'd0);
    check_stats("t5");

    // 6: reset in the middle of a frame
    do_reset();
    cfg_mode = MODE_FORCE; cfg_frame_len = 10'd4;
    vprob = 100; rprob = 0;
    load(2, 64'd0);
    for (int i = 0; i < 2; i++) begin
      drive();
      cycle();
    end
    chk("t6_pre_nin", 32'(n_in), 32'd2);
    axi_areset = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge axi_aclk);
    chk("t6_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t6_mdata", 32'(m_axis_tdata), 32'd0);
    chk("t6_mlast", 32'(m_axis_tlast), 32'd0);
    chk("t6_tready", 32'(s_axis_tready), 32'd0);
    chk("t6_busy", 32'(stat_busy), 32'd0);
    do_reset();
    rprob = 100;
    load(4, 64'd0);
    run("t6", 100);
    chk("t6_cnt", 32'(stat_frame_count), 32'd1);

    // random traffic with per-cycle config churn
    for (int r = 0; r < 6; r++) begin
      do_reset();
      rnd_cfg = 1'b1;
      vprob = $urandom_range(40, 100);
      rprob = $urandom_range(30, 100);
      for (int i = 0; i < 80; i++)
        inq.push_back({($urandom_range(99) < 15), DATA_W'($urandom)});
      run("rnd", 3000);
      rnd_cfg = 1'b0;
      check_stats("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
